osd_cmd_tx: RTL and testbench

OSD_CMD_TX -- requirements
Module: osd_cmd_tx

---
 rtl/osd_pkg.sv | 42 ++++
 rtl/spi_clk_div.sv | 43 ++++
 rtl/osd_cmd_tx.sv | 201 ++++++++++++++++++++
 tb/tb_osd_cmd_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// -----------------------------------------------------------------------------
// osd_pkg
// Shared definitions for the OSD command transmitter: command opcodes, line
// geometry, the transmitter state encoding and small helper functions.
// -----------------------------------------------------------------------------
package osd_pkg;

    // Command opcodes understood by the OSD controller.
    localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;  // low 5 bits carry the line number
    localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
    localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;

    // Bytes per OSD line; also the largest payload a single frame may carry.
    localparam int unsigned OSD_LINE_BYTES = 256;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        FETCH,
        HOLD,
        GAP
    } osd_state_t;

    // Payload lengths above one full line are clamped to one full line.
    function automatic logic [8:0] clamp_len(input logic [8:0] len);
        return (len > 9'(OSD_LINE_BYTES)) ? 9'(OSD_LINE_BYTES) : len;
    endfunction

    // States during which the frame select is held low.
    function automatic logic frame_active(input osd_state_t s);
        return (s == SETUP) || (s == SHIFT_LO) || (s == SHIFT_HI) ||
               (s == FETCH) || (s == HOLD);
    endfunction

    // States whose duration is measured by the SCK half-period divider.
    function automatic logic div_timed(input osd_state_t s);
        return (s == SETUP) || (s == SHIFT_LO) || (s == SHIFT_HI) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period timer for the SPI serial clock. Counts 0..CLK_DIV-1 and flags
// the last cycle of each half period. The FSM holds it in restart while it is
// in an untimed state, so every timed state begins with a full half period.
//
// Ports
//   clk_sys  in   system clock
//   reset    in   synchronous, active-high
//   restart  in   hold the count at zero (no tick while asserted)
//   tick     out  high on the final cycle of a half period
// -----------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process ordering.
        if (reset || restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Wrapping to zero on the tick lets back-to-back timed states chain
    // without a restart cycle in between.
    assign tick = !restart && (count == LAST);

endmodule

// File: rtl/osd_cmd_tx.sv
// -----------------------------------------------------------------------------
// osd_cmd_tx
// Serialises one OSD command frame: a command byte followed by 0..256 payload
// bytes, MSB first, framed by an active-low select and separated from the next
// frame by a guaranteed idle gap. SCK idles low; the receiver samples SPI_DI
// on the rising edge, and SPI_DI only moves while SCK is low.
//
// Parameters
//   CLK_DIV  clk_sys cycles per SCK half-period (>= 1)
//   SS_IDLE  clk_sys cycles SPI_SS3 stays high after a frame (>= 1)
//
// Ports
//   clk_sys     in   sole clock, rising edge
//   reset       in   synchronous, active-high; aborts any frame in flight
//   cmd_valid   in   frame request
//   cmd_ready   out  request accepted when cmd_valid && cmd_ready
//   cmd[7:0]    in   command byte
//   cmd_len[8:0]in   payload byte count, clamped to 256
//   data_valid  in   payload byte available
//   data_ready  out  payload byte consumed when data_valid && data_ready
//   data[7:0]   in   payload byte
//   SPI_SCK     out  serial clock
//   SPI_SS3     out  active-low frame select
//   SPI_DI      out  serial data
//   busy        out  high from accept until the end of the idle gap
//   done        out  one-cycle pulse as SPI_SS3 returns high
// -----------------------------------------------------------------------------
module osd_cmd_tx
    import osd_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SS_IDLE = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd,
    input  logic [8:0] cmd_len,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [7:0] data,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI,
    output logic       busy,
    output logic       done
);

    localparam int            GW       = (SS_IDLE > 1) ? $clog2(SS_IDLE) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(SS_IDLE - 1);

    osd_state_t    state, state_next;
    logic [6:0]    bits_left, bits_left_next;  // not-yet-driven bits of the current byte, MSB at [6]
    logic [2:0]    bit_cnt, bit_cnt_next;      // index of the bit currently on SPI_DI
    logic [8:0]    pay_cnt, pay_cnt_next;      // payload bytes still to fetch
    logic [GW-1:0] gap_cnt, gap_cnt_next;
    logic          di_next;

    logic phase_tick;
    logic div_restart;
    logic cmd_acc;
    logic data_acc;

    // The handshakes use the registered ready outputs, so what the DUT acts
    // on is exactly what the neighbouring blocks observe.
    assign cmd_acc     = cmd_valid && cmd_ready;
    assign data_acc    = data_valid && data_ready;
    assign div_restart = !div_timed(state);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_sys (clk_sys),
        .reset   (reset),
        .restart (div_restart),
        .tick    (phase_tick)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path leaves one unassigned and no latch is inferred.
        state_next     = state;
        bits_left_next = bits_left;
        bit_cnt_next   = bit_cnt;
        pay_cnt_next   = pay_cnt;
        gap_cnt_next   = gap_cnt;
        di_next        = SPI_DI;

        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    state_next     = SETUP;
                    bits_left_next = cmd[6:0];
                    bit_cnt_next   = 3'd7;
                    pay_cnt_next   = clamp_len(cmd_len);
                    di_next        = cmd[7];
                end
            end

            SETUP: begin
                if (phase_tick) begin
                    state_next = SHIFT_HI;
                end
            end

            SHIFT_HI: begin
                if (phase_tick) begin
                    if (bit_cnt != 3'd0) begin
                        // Next bit goes out on the same edge SCK falls.
                        state_next     = SHIFT_LO;
                        bit_cnt_next   = bit_cnt - 3'd1;
                        di_next        = bits_left[6];
                        bits_left_next = {bits_left[5:0], 1'b0};
                    end else if (pay_cnt != 9'd0) begin
                        state_next = FETCH;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end

            SHIFT_LO: begin
                if (phase_tick) begin
                    state_next = SHIFT_HI;
                end
            end

            FETCH: begin
                // SCK stays low and SPI_DI holds for as long as the source stalls.
                if (data_acc) begin
                    state_next     = SHIFT_LO;
                    bits_left_next = data[6:0];
                    bit_cnt_next   = 3'd7;
                    di_next        = data[7];
                    if (pay_cnt != 9'd0) begin
                        pay_cnt_next = pay_cnt - 9'd1;
                    end
                end
            end

            HOLD: begin
                if (phase_tick) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                    di_next      = 1'b0;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, datapath and output registers. Outputs are derived from the
    // next state so they change on the same edge as the state they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            bits_left  <= '0;
            bit_cnt    <= '0;
            pay_cnt    <= '0;
            gap_cnt    <= '0;
            SPI_SCK    <= 1'b0;
            SPI_SS3    <= 1'b1;
            SPI_DI     <= 1'b0;
            cmd_ready  <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            bits_left  <= bits_left_next;
            bit_cnt    <= bit_cnt_next;
            pay_cnt    <= pay_cnt_next;
            gap_cnt    <= gap_cnt_next;
            SPI_DI     <= di_next;
            SPI_SCK    <= (state_next == SHIFT_HI);
            SPI_SS3    <= !frame_active(state_next);
            cmd_ready  <= (state_next == IDLE);
            data_ready <= (state_next == FETCH);
            busy       <= (state_next != IDLE);
            done       <= (state == HOLD) && phase_tick;
        end
    end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_osd_cmd_tx
// Directed bench for osd_cmd_tx (CLK_DIV=4, SS_IDLE=8). A payload source
// supplies an incrementing byte stream, a bus monitor counts SCK edges and
// select/done activity, and an OSD receiver model decodes frames into lines.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_osd_cmd_tx;
    import osd_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd;
    logic [8:0] cmd_len;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data;
    logic       SPI_SCK;
    logic       SPI_SS3;
    logic       SPI_DI;
    logic       busy;
    logic       done;

    always #5 clk_sys = ~clk_sys;

    osd_cmd_tx #(
        .CLK_DIV (4),
        .SS_IDLE (8)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_len    (cmd_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS3    (SPI_SS3),
        .SPI_DI     (SPI_DI),
        .busy       (busy),
        .done       (done)
    );

    int n_cmp;
    int n_err;

    // ---------------- payload source and handshake counters ----------------
    logic       src_en;
    logic       stall;
    logic       mon_clr;
    logic       wipe_mem;
    logic       stall_chk;
    logic [7:0] src_base;
    logic [7:0] src_off;
    int         hs_cnt;
    int         acc_cnt;

    assign data_valid = src_en && !stall;
    assign data       = src_base + src_off;

    always @(posedge clk_sys) begin
        if (mon_clr) begin
            src_off <= 8'd0;
            hs_cnt  <= 0;
            acc_cnt <= 0;
        end else begin
            if (data_valid && data_ready) begin
                src_off <= src_off + 8'd1;
                hs_cnt  <= hs_cnt + 1;
            end
            if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
        end
    end

    // ---------------- bus monitor and OSD receiver model ----------------
    int         edge_cnt, ss_low_cnt, done_cnt, unstable_cnt, overlap_cnt;
    int         stall_sck, hi_run, min_gap, nbit;
    logic       seen_frame;
    logic       prev_sck = 1'b0;
    logic       prev_ss3 = 1'b1;
    logic       prev_di  = 1'b0;
    logic [7:0] cur;
    logic [7:0] hdr;
    logic [7:0] rx_q[$];
    logic [7:0] last_frame[$];
    logic [7:0] osd_mem [32][256];

    always @(negedge clk_sys) begin
        if (mon_clr) begin
            edge_cnt = 0; ss_low_cnt = 0; done_cnt = 0; unstable_cnt = 0;
            overlap_cnt = 0; stall_sck = 0; hi_run = 0; min_gap = 1000000;
            nbit = 0; seen_frame = 1'b0; cur = 8'd0;
            rx_q.delete();
            if (wipe_mem) begin
                for (int l = 0; l < 32; l++)
                    for (int b = 0; b < 256; b++) osd_mem[l][b] = 8'hFF;
            end
        end else begin
            if (!prev_sck && SPI_SCK && !SPI_SS3) begin
                edge_cnt++;
                cur = {cur[6:0], SPI_DI};
                nbit++;
                if (nbit == 8) begin
                    rx_q.push_back(cur);
                    nbit = 0;
                end
            end
            if (prev_sck && SPI_SCK && (SPI_DI !== prev_di)) unstable_cnt++;
            if (!SPI_SS3) ss_low_cnt++;
            if (done) done_cnt++;
            if (cmd_ready && busy) overlap_cnt++;
            if (stall_chk && SPI_SCK) stall_sck++;
            if (SPI_SS3) begin
                hi_run++;
            end else begin
                if (prev_ss3 && seen_frame && (hi_run < min_gap)) min_gap = hi_run;
                seen_frame = 1'b1;
                hi_run     = 0;
            end
            if (!prev_ss3 && SPI_SS3) begin
                last_frame = rx_q;
                if (rx_q.size() > 0) begin
                    hdr = rx_q[0];
                    if ((hdr & 8'hE0) == OSD_CMD_WRITE) begin
                        for (int k = 1; k < rx_q.size() && k <= 256; k++)
                            osd_mem[hdr[4:0]][k-1] = rx_q[k];
                    end
                end
                rx_q.delete();
                nbit = 0;
            end
        end
        prev_sck = SPI_SCK;
        prev_ss3 = SPI_SS3;
        prev_di  = SPI_DI;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs read 2 ns after the rising edge.
    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] c, input logic [8:0] l, input string tag);
        int t = 0;
        while (!cmd_ready && t < 1000) begin step(); t++; end
        check({tag, "_ready"}, cmd_ready, 1'b1);
        cmd       = c;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int n_done, input string tag);
        int t = 0;
        while ((done_cnt < n_done || busy) && t < 40000) begin step(); t++; end
        check({tag, "_done"}, done_cnt, n_done);
    endtask

    function automatic int payload_errs(input logic [7:0] c, input logic [7:0] base, input int n);
        int e = 0;
        if (last_frame.size() != n + 1) return 1000 + last_frame.size();
        if (last_frame[0] !== c) e++;
        for (int k = 1; k <= n; k++)
            if (last_frame[k] !== 8'(base + 8'(k - 1))) e++;
        return e;
    endfunction

    function automatic int line_errs(input int line, input logic [7:0] base);
        int e = 0;
        for (int i = 0; i < 256; i++)
            if (osd_mem[line][i] !== 8'(base + 8'(i))) e++;
        return e;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int e0;
        int h0;
        n_cmp = 0; n_err = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd = 8'd0; cmd_len = 9'd0;
        src_en = 1'b0; stall = 1'b0; src_base = 8'd0;
        mon_clr = 1'b1; wipe_mem = 1'b1; stall_chk = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_sck",        SPI_SCK,    1'b0);
        check("rst_ss3",        SPI_SS3,    1'b1);
        check("rst_di",         SPI_DI,     1'b0);
        check("rst_cmd_ready",  cmd_ready,  1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_done",       done,       1'b0);
        reset = 1'b0; wipe_mem = 1'b0;
        step();
        check("rst_idle_ready", cmd_ready, 1'b1);
        mon_clr = 1'b0;

        // Enable command, no payload
        clear_mon();
        start_frame(OSD_CMD_ENABLE, 9'd0, "t1");
        wait_end(1, "t1");
        check("t1_edges",  edge_cnt, 8);
        check("t1_nbytes", last_frame.size(), 1);
        check("t1_cmd",    (last_frame.size() > 0) ? last_frame[0] : 8'hxx, 8'h41);
        check("t1_ss_low", ss_low_cnt, 68);
        check("t1_hs",     hs_cnt, 0);
        check("t1_stable", unstable_cnt, 0);

        // Full line write to line 7
        clear_mon();
        src_base = 8'h00; src_en = 1'b1;
        start_frame(8'h27, 9'd256, "t2");
        wait_end(1, "t2");
        src_en = 1'b0;
        check("t2_edges",   edge_cnt, 2056);
        check("t2_hs",      hs_cnt, 256);
        check("t2_ss_low",  ss_low_cnt, 16708);
        check("t2_payload", payload_errs(8'h27, 8'h00, 256), 0);
        check("t2_line7",   line_errs(7, 8'h00), 0);
        check("t2_stable",  unstable_cnt, 0);

        // Source stall of 50 cycles mid-payload
        clear_mon();
        src_base = 8'h80; src_en = 1'b1;
        start_frame(8'h23, 9'd6, "t3");
        t = 0;
        while (hs_cnt < 2 && t < 2000) begin step(); t++; end
        check("t3_hs2", hs_cnt, 2);
        stall = 1'b1;
        t = 0;
        while (!data_ready && t < 2000) begin step(); t++; end
        check("t3_fetch", data_ready, 1'b1);
        e0 = edge_cnt;
        stall_chk = 1'b1;
        repeat (50) step();
        stall_chk = 1'b0;
        check("t3_stall_edges", edge_cnt - e0, 0);
        check("t3_stall_sck",   stall_sck, 0);
        check("t3_stall_wait",  data_ready, 1'b1);
        stall = 1'b0;
        wait_end(1, "t3");
        src_en = 1'b0;
        check("t3_edges",   edge_cnt, 56);
        check("t3_hs",      hs_cnt, 6);
        check("t3_payload", payload_errs(8'h23, 8'h80, 6), 0);
        check("t3_stable",  unstable_cnt, 0);

        // Two queued frames with cmd_valid held high
        clear_mon();
        cmd = OSD_CMD_DISABLE; cmd_len = 9'd0; cmd_valid = 1'b1;
        t = 0;
        while (acc_cnt < 2 && t < 2000) begin step(); t++; end
        cmd_valid = 1'b0;
        wait_end(2, "t4");
        check("t4_accepts", acc_cnt, 2);
        check("t4_edges",   edge_cnt, 16);
        check("t4_gap_ge8", (min_gap >= 8) ? 1 : 0, 1);
        check("t4_rdy_busy_overlap", overlap_cnt, 0);

        // Reset during payload byte 3 of a write
        clear_mon();
        src_base = 8'h30; src_en = 1'b1;
        start_frame(8'h25, 9'd10, "t5");
        t = 0;
        while (hs_cnt < 3 && t < 2000) begin step(); t++; end
        check("t5_hs3", hs_cnt, 3);
        repeat (5) step();
        h0 = hs_cnt;
        reset = 1'b1;
        step();
        check("t5_ss3",        SPI_SS3,    1'b1);
        check("t5_sck",        SPI_SCK,    1'b0);
        check("t5_data_ready", data_ready, 1'b0);
        check("t5_busy",       busy,       1'b0);
        repeat (20) step();
        check("t5_no_done", done_cnt, 0);
        check("t5_no_hs",   hs_cnt, h0);
        reset = 1'b0;
        step();
        check("t5_ready", cmd_ready, 1'b1);
        src_en = 1'b0;

        // Oversized length clamps to one line
        clear_mon();
        src_base = 8'h10; src_en = 1'b1;
        start_frame(OSD_CMD_WRITE, 9'd300, "t6");
        wait_end(1, "t6");
        src_en = 1'b0;
        check("t6_hs",      hs_cnt, 256);
        check("t6_edges",   edge_cnt, 2056);
        check("t6_payload", payload_errs(OSD_CMD_WRITE, 8'h10, 256), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
